// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and
// combinational full/empty flags decoded from the pointer registers.
module async_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Handshake: wr_en/rd_en are requests; full/empty act as the inverted
   // ready. A transfer happens only on an edge where request && !flag.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   assign empty = (wptr == rptr);
   assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

   // Storage has no reset; entries are unobservable until rewritten.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
      end else if (wr_ok) begin
         wptr <= wptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr <= '0;
         dout <= '0;
      end else if (rd_ok) begin
         rptr <= rptr + PTR_ONE;
         dout <= mem[rptr[ADDR_WIDTH-1:0]];
      end
   end

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: a vector table for reset/fill/drain, then hand-written
// sequences for wrap, simultaneous access, full/empty corners and mid-op reset.
module tb_async_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: queue of stored entries plus last read value.
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] m_dout = '0;

   typedef struct {
      logic          rst;
      logic          wr;
      logic          rd;
      logic [DW-1:0] din;
      logic [DW-1:0] exp_dout;
      logic          exp_full;
      logic          exp_empty;
   } vec_t;

   vec_t vecs [$];

   async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                               input logic [DW-1:0] ed, input logic ef, input logic ee);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = rd; v.din = d;
      v.exp_dout = ed; v.exp_full = ef; v.exp_empty = ee;
      return v;
   endfunction

   // Drive one cycle, advance the model, compare DUT against the model.
   task automatic apply(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      bit was_full;
      bit was_empty;
      @(negedge clk);
      rst = r; wr_en = w; rd_en = rd; din = d;
      @(posedge clk);
      #1;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (r) begin
         exp_q.delete();
         m_dout = '0;
      end else begin
         if (rd && !was_empty) m_dout = exp_q.pop_front();
         if (w && !was_full) exp_q.push_back(d);
      end
      check("dout",  32'(dout),  32'(m_dout));
      check("full",  32'(full),  32'(exp_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
   endtask

   initial begin
      vec_t v;
      logic [DW-1:0] val;

      // Reset for two cycles with both requests asserted.
      vecs.push_back(mk(1, 1, 1, 8'h55, 8'h00, 0, 1));
      vecs.push_back(mk(1, 1, 1, 8'h66, 8'h00, 0, 1));
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(0, 1, 0, DW'(i), 8'h00, i == 8, 0));
      vecs.push_back(mk(0, 1, 0, 8'h09, 8'h00, 1, 0));
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(0, 0, 1, 8'h00, DW'(i), 0, i == 8));
      vecs.push_back(mk(0, 0, 1, 8'h00, 8'h08, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         apply(v.rst, v.wr, v.rd, v.din);
         check("vec_dout",  32'(dout),  32'(v.exp_dout));
         check("vec_full",  32'(full),  32'(v.exp_full));
         check("vec_empty", 32'(empty), 32'(v.exp_empty));
      end

      // Wrap: four rounds of 5 writes then 5 reads, values from 0x10.
      val = 8'h10;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 5; k++) begin
            apply(0, 1, 0, val);
            val++;
         end
         for (int k = 0; k < 5; k++) apply(0, 0, 1, 8'h00);
         check("wrap_empty", 32'(empty), 32'(1));
      end

      // Simultaneous with 3 entries held.
      for (int k = 0; k < 3; k++) apply(0, 1, 0, DW'(8'h30 + k));
      for (int k = 0; k < 10; k++) apply(0, 1, 1, DW'(8'h40 + k));
      for (int k = 0; k < 3; k++) apply(0, 0, 1, 8'h00);
      check("sim_dout_last", 32'(dout), 32'(8'h49));

      // Simultaneous while empty: only the write lands.
      apply(0, 1, 1, 8'h77);
      check("empty_sim_empty", 32'(empty), 32'(0));
      check("empty_sim_dout",  32'(dout),  32'(8'h49));
      apply(0, 0, 1, 8'h00);
      check("empty_sim_rd", 32'(dout), 32'(8'h77));

      // Simultaneous while full: only the read lands.
      for (int k = 0; k < DEPTH; k++) apply(0, 1, 0, DW'(8'h80 + k));
      check("fill_full", 32'(full), 32'(1));
      apply(0, 1, 1, 8'hEE);
      check("full_sim_dout", 32'(dout), 32'(8'h80));
      check("full_sim_full", 32'(full), 32'(0));
      for (int k = 0; k < DEPTH - 1; k++) apply(0, 0, 1, 8'h00);
      check("full_sim_last", 32'(dout), 32'(8'h87));

      // Mid-operation reset.
      for (int k = 0; k < 4; k++) apply(0, 1, 0, DW'(8'h90 + k));
      apply(1, 0, 0, 8'h00);
      check("midrst_empty", 32'(empty), 32'(1));
      apply(0, 1, 0, 8'hAA);
      apply(0, 0, 1, 8'h00);
      check("midrst_dout", 32'(dout), 32'(8'hAA));

      // Random traffic against the model.
      for (int k = 0; k < 300; k++)
         apply(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, DW'($urandom_range(0, 255)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, the bit width of din and dout.
REQ-002 The block SHALL take parameter DEPTH, default 8, the number of storage entries; it must be a power of two, at least 2.
REQ-003 The block SHALL derive ADDR_WIDTH = log2(DEPTH) (3 at default) internally; it is not a user override.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-006 Port: rst, input, 1 bit; synchronous, active-high reset.
REQ-007 Port: wr_en, input, 1 bit; write request, sampled at the rising edge of clk.
REQ-008 Port: rd_en, input, 1 bit; read request, sampled at the rising edge of clk.
REQ-009 Port: din, input, DATA_WIDTH bits; write data, captured on an accepted write.
REQ-010 Port: dout, output, DATA_WIDTH bits; registered read data.
REQ-011 Port: full, output, 1 bit; high when DEPTH entries are stored.
REQ-012 Port: empty, output, 1 bit; high when 0 entries are stored.

Function
REQ-013 The block SHALL store entries in a DEPTH x DATA_WIDTH memory addressed by a write pointer and a read pointer, each ADDR_WIDTH+1 bits wide (MSB = wrap bit).
REQ-014 A write SHALL be accepted when wr_en=1 and full=0: mem[wptr[ADDR_WIDTH-1:0]] <= din, and wptr increments by 1 modulo 2^(ADDR_WIDTH+1).
REQ-015 A read SHALL be accepted when rd_en=1 and empty=0: dout <= mem[rptr[ADDR_WIDTH-1:0]], and rptr increments by 1 modulo 2^(ADDR_WIDTH+1).
REQ-016 Read latency SHALL be one cycle: dout shows the oldest entry after the same rising edge that accepts the read.
REQ-017 dout SHALL hold its previous value on any cycle without an accepted read.
REQ-018 empty SHALL be 1 exactly when wptr == rptr, including the wrap bit.
REQ-019 full SHALL be 1 exactly when the wrap bits differ and the low ADDR_WIDTH bits are equal.
REQ-020 full and empty SHALL be combinational from the registered pointers, so they reflect each accepted operation in the cycle after its edge.
REQ-021 A write while full=1 SHALL be ignored: no memory write, no pointer change, no corruption of stored data.
REQ-022 A read while empty=1 SHALL be ignored: no pointer change, dout unchanged.
REQ-023 A simultaneous write and read with 0 < occupancy < DEPTH SHALL both be accepted; occupancy is unchanged.
REQ-024 A simultaneous write and read while empty SHALL accept the write only; the read is rejected.
REQ-025 A simultaneous write and read while full SHALL accept the read only; the write is rejected.
REQ-026 Pointer wrap SHALL be seamless: data order stays first-in first-out across any number of wraps.
REQ-027 Data SHALL be returned in exactly the order accepted, with no loss or duplication.

Reset
REQ-028 While rst=1 at a rising clk edge, the block SHALL set wptr=0, rptr=0 and dout=0, giving empty=1 and full=0 after that edge.
REQ-029 rst SHALL take priority over wr_en and rd_en in the same cycle.
REQ-030 Memory contents need not be cleared by reset; they are unobservable until rewritten.
REQ-031 A reset mid-operation SHALL discard all stored entries; the first write after reset is the first entry read.

Verification
REQ-032 Reset: rst=1 for 2 cycles -> empty=1, full=0, dout=0; wr_en/rd_en during reset have no effect.
REQ-033 Fill: write 1..8 on consecutive cycles -> empty falls after the first write, full=1 after the 8th; a 9th write of 9 is dropped.
REQ-034 Drain: after the fill, rd_en=1 for 8 cycles -> dout = 1,2,...,8 one cycle after each read; empty=1 after the 8th; a 9th read leaves dout=8.
REQ-035 Wrap: write 5 entries and read 5, repeated 4 times with values 0x10 upward -> every value returns in order; flags are correct at each boundary.
REQ-036 Simultaneous: with 3 entries held, wr_en=rd_en=1 for 10 cycles -> occupancy stays 3 and output order matches input order; when empty, a simultaneous write/read accepts only the write (empty=0 next cycle, dout unchanged).
REQ-037 Mid-op reset: after writing 4 entries, assert rst for 1 cycle -> empty=1; then write 0xAA and read it -> dout=0xAA.
